// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier.
// Holds the M-extension op encodings, the FSM state type and the counter width helper.
// No logic lives here.
package mult_pkg;

  // Multiply ops as encoded by the execute stage
  typedef enum logic [1:0] {
    OP_MUL    = 2'b00,
    OP_MULH   = 2'b01,
    OP_MULHSU = 2'b10,
    OP_MULHU  = 2'b11
  } op_t;

  // Control states of the iterative multiplier
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    CALC = 3'd2,
    SIGN = 3'd3,
    DONE = 3'd4
  } state_t;

  // Width of the iteration counter for a given operand size
  function automatic int cnt_width(input int size);
    return $clog2(size);
  endfunction

endpackage

// File: rtl/SOMADOR.sv
// Ripple-carry adder: S = X + Y + Cin, with carry out.
// Purely combinational, zero latency.
// No handshake; the outputs follow the inputs.
module SOMADOR #(
  parameter int SIZE = 32
) (
  input  logic [SIZE-1:0] X,
  input  logic [SIZE-1:0] Y,
  input  logic            Cin,
  output logic [SIZE-1:0] S,
  output logic            Cout
);

  logic carry;

  // Bit-serial carry chain from LSB to MSB
  always_comb begin
    S     = '0;
    carry = Cin;
    for (int i = 0; i < SIZE; i++) begin
      S[i]  = X[i] ^ Y[i] ^ carry;
      carry = (X[i] & Y[i]) | (carry & (X[i] ^ Y[i]));
    end
    Cout = carry;
  end

endmodule

// File: rtl/multiplicador_seq.sv
// Iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU, one partial product per cycle.
// Latency: done pulses SIZE+2 cycles after the edge that accepts start.
// start is accepted only while ready is high (IDLE/DONE); starts while busy are dropped.
module multiplicador_seq
  import mult_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [SIZE-1:0] a,
  input  logic [SIZE-1:0] b,
  output logic            ready,
  output logic            done,
  output logic [SIZE-1:0] result
);

  localparam int CNT_W = cnt_width(SIZE);

  state_t              state_q;
  op_t                 op_q;
  logic [SIZE-1:0]     a_q, b_q, mcand_q, result_q;
  logic [2*SIZE-1:0]   p_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                neg_q, ready_q, done_q;

  logic                sign_a, sign_b;
  logic [SIZE-1:0]     acc_y, acc_s;
  logic                acc_cout;
  logic [2*SIZE-1:0]   neg_x, neg_y, neg_s, p_fin;
  logic                neg_cout_unused;

  // MUL is treated as signed x signed; its low half is the same either way
  assign sign_a = (op_q != OP_MULHU) & a_q[SIZE-1];
  assign sign_b = ((op_q == OP_MUL) | (op_q == OP_MULH)) & b_q[SIZE-1];

  // Accumulate adder: high half of P plus the multiplicand when the current multiplier bit is set
  assign acc_y = p_q[0] ? mcand_q : '0;

  SOMADOR #(.SIZE(SIZE)) u_acc (
    .X    (p_q[2*SIZE-1:SIZE]),
    .Y    (acc_y),
    .Cin  (1'b0),
    .S    (acc_s),
    .Cout (acc_cout)
  );

  // Shared negate adder. In SIGN it computes ~P + 1 over the full width.
  // In PREP it negates both operands at once: the low half gets +1 from Cin and the
  // high half gets +1 from Y. The low half never carries into the high half, because
  // it is zero when b is not negated and ~b has a clear MSB when it is.
  always_comb begin
    neg_x = ~p_q;
    neg_y = '0;
    if (state_q == PREP) begin
      neg_x = {~a_q, (sign_b ? ~b_q : {SIZE{1'b0}})};
      neg_y = {{(SIZE-1){1'b0}}, 1'b1, {SIZE{1'b0}}};
    end
  end

  SOMADOR #(.SIZE(2*SIZE)) u_neg (
    .X    (neg_x),
    .Y    (neg_y),
    .Cin  (1'b1),
    .S    (neg_s),
    .Cout (neg_cout_unused)
  );

  assign p_fin = neg_q ? neg_s : p_q;

  // Control FSM with registered ready/done/result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      op_q     <= OP_MUL;
      a_q      <= '0;
      b_q      <= '0;
      mcand_q  <= '0;
      p_q      <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op_t'(op);
            ready_q <= 1'b0;
            state_q <= PREP;
          end else begin
            state_q <= IDLE;
          end
        end
        PREP: begin
          mcand_q <= sign_a ? neg_s[2*SIZE-1:SIZE] : a_q;
          p_q     <= {{SIZE{1'b0}}, (sign_b ? neg_s[SIZE-1:0] : b_q)};
          neg_q   <= sign_a ^ sign_b;
          cnt_q   <= '0;
          state_q <= CALC;
        end
        CALC: begin
          // The adder carry becomes the new MSB before the right shift
          p_q   <= {acc_cout, acc_s, p_q[SIZE-1:1]};
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(SIZE-1)) begin
            state_q <= SIGN;
          end
        end
        SIGN: begin
          p_q      <= p_fin;
          result_q <= (op_q == OP_MUL) ? p_fin[SIZE-1:0] : p_fin[2*SIZE-1:SIZE];
          done_q   <= 1'b1;
          ready_q  <= 1'b1;
          state_q  <= DONE;
        end
        default: begin
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready  = ready_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
